// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and length/mask helpers for the pattern detector
package seq_det_pkg;
  typedef enum logic {ST_IDLE, ST_HUNT} state_e;
  localparam int MAX_PAT_W = 64;
  function automatic int len_w(int pat_w);
    return $clog2(pat_w + 1);
  endfunction
  function automatic int clamp_len(int len, int pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction
  function automatic logic [MAX_PAT_W-1:0] len_mask(int len);
    return (len >= MAX_PAT_W) ? '1 : (MAX_PAT_W'(1) << len) - 1'b1;
  endfunction
endpackage

// File: rtl/seq_det_history.sv
// seq_det_history: bit-history shift register with saturating fill counter
module seq_det_history #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             clear,
  input  logic             restart,
  input  logic             in,
  output logic [PAT_W-1:0] nhist,
  output logic [LEN_W-1:0] fill
);
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  assign nhist = {hist_q, in};
  assign fill = fill_q;
  // the oldest bit falls off the top; restart keeps the bits but forgets how many are valid
  always_comb begin
    hist_d = clear ? '0 : shift ? nhist[PAT_W-2:0] : hist_q;
    fill_d = (clear || (shift && restart)) ? '0 :
             (!shift || fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
  end
  // history state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: programmable serial pattern detector; SEQ_DET_MASK_EN adds cfg_mask don't-care bits
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 16,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask,
`endif
  input  logic             en,
  input  logic             in_valid,
  input  logic             in,
  output logic             armed,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);
  state_e st_q, st_d;
  logic [PAT_W-1:0] pat_q, pat_d, nhist, cmp_mask;
  logic [LEN_W-1:0] len_q, len_d, fill;
  logic ovl_q, ovl_d, out_q, out_d, accept, hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SEQ_DET_MASK_EN
  logic [PAT_W-1:0] mask_q, mask_d;
  assign mask_d = cfg_load ? cfg_mask : mask_q;
  assign cmp_mask = PAT_W'(len_mask(int'(len_q))) & ~mask_q;
  // don't-care mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_q <= '0;
    else mask_q <= mask_d;
  end
`else
  assign cmp_mask = PAT_W'(len_mask(int'(len_q)));
`endif
  assign accept = (st_q == ST_HUNT) && en && in_valid && !cfg_load;
  assign hit = ((LEN_W+1)'(fill) + 1'b1 >= (LEN_W+1)'(len_q)) &&
               (((nhist ^ pat_q) & cmp_mask) == '0);
  assign armed = (st_q == ST_HUNT);
  assign out = out_q;
  assign match_cnt = cnt_q;
  seq_det_history #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_hist (
    .clk(clk),
    .reset(reset),
    .shift(accept),
    .clear(cfg_load),
    .restart(hit && !ovl_q),
    .in(in),
    .nhist(nhist),
    .fill(fill)
  );
  // next state: cfg_load (re)arms and wipes counts; hits pulse out and bump the saturating count
  always_comb begin
    st_d = cfg_load ? ST_HUNT : st_q;
    pat_d = cfg_load ? cfg_pattern : pat_q;
    len_d = cfg_load ? LEN_W'(clamp_len(int'(cfg_len), PAT_W)) : len_q;
    ovl_d = cfg_load ? cfg_overlap : ovl_q;
    out_d = accept && hit;
    cnt_d = cfg_load ? '0 : (out_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  // state and configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= ST_IDLE;
      pat_q <= '0;
      len_q <= '0;
      ovl_q <= 1'b0;
      out_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
